// File: rtl/pcc_pkg.sv
// Shared definitions for the popcount-compare sequencer: FSM states and
// the width helpers that size the signed difference and the beat count.
package pcc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One extra bit over the magnitude so -NEG_W..+POS_W fits as two's complement.
    function automatic int calc_dw(input int pos_w, input int neg_w);
        return $clog2(max_w(pos_w, neg_w) + 1) + 1;
    endfunction

    function automatic int calc_nbeats(input int pos_w, input int neg_w, input int chunk);
        return (max_w(pos_w, neg_w) + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/pcc_seq_popcnt_chunk.sv
// Combinational population count of one CHUNK-wide slice.
module popcnt_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0]              i_bits,
    output logic [$clog2(W+1)-1:0]    o_count
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/pcc_seq.sv
// Multi-cycle comparator: accumulates popcount(pos)-popcount(neg) CHUNK bits
// per cycle, then presents the signed difference and the compare result.
module pcc_seq
    import pcc_pkg::*;
#(
    parameter int POS_W = 16,
    parameter int NEG_W = 16,
    parameter int CHUNK = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [POS_W-1:0]                       pos,
    input  logic [NEG_W-1:0]                       neg,
    input  logic                                   strict,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   outval,
    output logic signed [calc_dw(POS_W, NEG_W)-1:0] diff
);

    localparam int DW     = calc_dw(POS_W, NEG_W);
    localparam int NBEATS = calc_nbeats(POS_W, NEG_W, CHUNK);
    localparam int PADW   = NBEATS * CHUNK;
    localparam int CW     = $clog2(CHUNK + 1);
    localparam int BW     = $clog2(NBEATS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS);

    state_t                 r_state;
    logic                   r_in_ready;
    logic [PADW-1:0]        r_pos_sh;
    logic [PADW-1:0]        r_neg_sh;
    logic                   r_strict;
    logic [BW-1:0]          r_beat;
    logic signed [DW-1:0]   r_acc;
    logic signed [DW-1:0]   r_diff;
    logic                   r_outval;
    logic                   r_out_valid;

    logic [CW-1:0]          w_cnt_pos;
    logic [CW-1:0]          w_cnt_neg;
    logic signed [DW-1:0]   w_step;

    popcnt_chunk #(.W(CHUNK)) u_pc_pos (
        .i_bits  (r_pos_sh[CHUNK-1:0]),
        .o_count (w_cnt_pos)
    );

    popcnt_chunk #(.W(CHUNK)) u_pc_neg (
        .i_bits  (r_neg_sh[CHUNK-1:0]),
        .o_count (w_cnt_neg)
    );

    assign w_step = DW'(w_cnt_pos) - DW'(w_cnt_neg);

    // Operands are padded to whole beats, so the tail bits shift in as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_pos_sh    <= '0;
            r_neg_sh    <= '0;
            r_strict    <= 1'b0;
            r_beat      <= '0;
            r_acc       <= '0;
            r_diff      <= '0;
            r_outval    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pos_sh   <= PADW'(pos);
                        r_neg_sh   <= PADW'(neg);
                        r_strict   <= strict;
                        r_beat     <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    if (r_beat != LAST_BEAT) begin
                        r_acc    <= r_acc + w_step;
                        r_pos_sh <= r_pos_sh >> CHUNK;
                        r_neg_sh <= r_neg_sh >> CHUNK;
                        r_beat   <= r_beat + BW'(1);
                    end else begin
                        // Extra cycle after the last beat registers the result.
                        r_diff      <= r_acc;
                        r_outval    <= !r_acc[DW-1] && (r_strict ? (r_acc != '0) : 1'b1);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_diff      <= '0;
                        r_outval    <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign outval    = r_outval;
    assign diff      = r_diff;

endmodule

// File: tb/tb_pcc_seq.sv
// Scoreboard bench for pcc_seq: a 16/16/4 instance under directed and random
// traffic, plus a 6/10/4 instance for the uneven-width case.
module tb_pcc_seq;

    localparam int A_NBEATS = (16 + 4 - 1) / 4;
    localparam int B_NBEATS = (10 + 4 - 1) / 4;

    typedef struct {
        int diff;
        bit outval;
        int acceptCyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              inValid;
    logic              inReady;
    logic [15:0]       pos;
    logic [15:0]       neg;
    logic              strict;
    logic              outValid;
    logic              outReady;
    logic              outval;
    logic signed [5:0] diff;

    logic              rstB;
    logic              bInValid;
    logic              bInReady;
    logic [5:0]        bPos;
    logic [9:0]        bNeg;
    logic              bStrict;
    logic              bOutValid;
    logic              bOutReady;
    logic              bOutval;
    logic signed [4:0] bDiff;

    exp_t sbQ[$];
    int   asserts = 0;
    int   fails = 0;
    int   cyc = 0;
    int   issued = 0;
    int   abandoned = 0;
    int   resultsSeen = 0;
    int   readyMode = 2;
    bit   monOn = 1'b0;
    bit   prevValid = 1'b0;

    pcc_seq #(.POS_W(16), .NEG_W(16), .CHUNK(4)) dutA (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .pos       (pos),
        .neg       (neg),
        .strict    (strict),
        .out_valid (outValid),
        .out_ready (outReady),
        .outval    (outval),
        .diff      (diff)
    );

    pcc_seq #(.POS_W(6), .NEG_W(10), .CHUNK(4)) dutB (
        .clk       (clk),
        .rst       (rstB),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .pos       (bPos),
        .neg       (bNeg),
        .strict    (bStrict),
        .out_valid (bOutValid),
        .out_ready (bOutReady),
        .outval    (bOutval),
        .diff      (bDiff)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic exp_t model(input logic [15:0] p, input logic [15:0] n, input logic s);
        exp_t e;
        e.diff      = $countones(p) - $countones(n);
        e.outval    = s ? (e.diff > 0) : (e.diff >= 0);
        e.acceptCyc = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer handshake: random, held low or held high depending on the phase.
    initial begin
        outReady = 1'b1;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       outReady = 1'($urandom_range(0, 1));
                1:       outReady = 1'b0;
                default: outReady = 1'b1;
            endcase
        end
    end

    // Monitor: every result cycle is compared to the scoreboard head, which
    // also covers stability while the consumer stalls.
    initial forever begin
        @(negedge clk);
        #2;
        if (monOn) begin
            if (outValid) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedResult", 1, 0);
                end else begin
                    checkOutput("diff", int'(diff), sbQ[0].diff);
                    checkOutput("outval", int'(outval), int'(sbQ[0].outval));
                    checkOutput("inReadyWhileValid", int'(inReady), 0);
                    if (!prevValid)
                        checkOutput("latency", cyc - sbQ[0].acceptCyc, A_NBEATS + 1);
                    if (outReady && !rst) begin
                        void'(sbQ.pop_front());
                        resultsSeen++;
                    end
                end
            end else begin
                checkOutput("idleDiffZero", int'(diff), 0);
                checkOutput("idleOutvalZero", int'(outval), 0);
            end
        end
        prevValid = outValid;
    end

    task automatic setReady(input int m);
        @(posedge clk);
        #1 readyMode = m;
    endtask

    task automatic applyStimulus(input logic [15:0] p, input logic [15:0] n, input logic s);
        int   w;
        exp_t e;
        @(negedge clk);
        inValid = 1'b1;
        pos = p;
        neg = n;
        strict = s;
        w = 0;
        while (!inReady && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            checkOutput("acceptTimeout", w, 0);
            inValid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        e = model(p, n, s);
        e.acceptCyc = cyc;
        sbQ.push_back(e);
        issued++;
        // Scramble the operand bus so a design that re-samples it shows up.
        inValid = 1'b0;
        pos = 16'($urandom());
        neg = 16'($urandom());
        strict = 1'($urandom_range(0, 1));
    endtask

    task automatic waitValid();
        int w = 0;
        while (!outValid && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) checkOutput("validTimeout", w, 0);
    endtask

    task automatic waitDrain(input int budget);
        int w = 0;
        while (sbQ.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drainQueue", sbQ.size(), 0);
    endtask

    task automatic flushAfterReset();
        abandoned += sbQ.size();
        sbQ.delete();
    endtask

    task automatic runB(input logic [5:0] p, input logic [9:0] n, input logic s);
        int   t;
        exp_t e;
        e = model(16'(p), 16'(n), s);
        @(negedge clk);
        bInValid = 1'b1;
        bPos = p;
        bNeg = n;
        bStrict = s;
        t = 0;
        while (!bInReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checkOutput("bAcceptTimeout", t, 0);
            bInValid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bInValid = 1'b0;
        bPos = 6'($urandom());
        bNeg = 10'($urandom());
        t = 0;
        while (!bOutValid && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("bLatency", t, B_NBEATS + 1);
        checkOutput("bDiff", int'(bDiff), e.diff);
        checkOutput("bOutval", int'(bOutval), int'(e.outval));
        @(negedge clk);
        checkOutput("bValidDropped", int'(bOutValid), 0);
    endtask

    initial begin
        rst = 1'b1;
        rstB = 1'b1;
        inValid = 1'b0;
        pos = '0;
        neg = '0;
        strict = 1'b0;
        bInValid = 1'b0;
        bPos = '0;
        bNeg = '0;
        bStrict = 1'b0;
        bOutReady = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstInReady", int'(inReady), 1);
        checkOutput("rstOutValid", int'(outValid), 0);
        checkOutput("rstDiff", int'(diff), 0);
        checkOutput("rstOutval", int'(outval), 0);
        checkOutput("rstBInReady", int'(bInReady), 1);
        rst = 1'b0;
        rstB = 1'b0;
        monOn = 1'b1;

        // Full-positive and balanced cases, both compare modes.
        applyStimulus(16'hFFFF, 16'h0000, 1'b0);
        waitDrain(40);
        applyStimulus(16'h000F, 16'hF000, 1'b0);
        waitDrain(40);
        applyStimulus(16'h000F, 16'hF000, 1'b1);
        waitDrain(40);

        // Stalled consumer: result must hold, then return to idle one cycle after release.
        setReady(1);
        applyStimulus(16'h0001, 16'h00FF, 1'b0);
        waitValid();
        repeat (3) @(negedge clk);
        checkOutput("stallValidHeld", int'(outValid), 1);
        setReady(2);
        @(negedge clk);
        @(negedge clk);
        #3;
        checkOutput("idleAfterRelease", int'(inReady), 1);
        checkOutput("validAfterRelease", int'(outValid), 0);

        // Reset on the second accumulate cycle abandons the operation.
        applyStimulus(16'h1234, 16'h0F0F, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flushAfterReset();
        checkOutput("accRstInReady", int'(inReady), 1);
        checkOutput("accRstOutValid", int'(outValid), 0);
        applyStimulus(16'hA5A5, 16'h0001, 1'b1);
        waitDrain(40);

        // Reset while a stalled result is pending: it must never be delivered.
        setReady(1);
        applyStimulus(16'hFF00, 16'h0003, 1'b0);
        waitValid();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flushAfterReset();
        checkOutput("doneRstOutValid", int'(outValid), 0);
        setReady(2);
        repeat (6) @(negedge clk);
        checkOutput("doneRstStillIdle", int'(inReady), 1);

        // Random back-to-back traffic with a random consumer.
        setReady(0);
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            applyStimulus(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
        end
        waitDrain(400);
        setReady(2);

        // Uneven widths: 6-bit pos, 10-bit neg, three beats.
        runB(6'h3F, 10'h3FF, 1'b0);
        for (int k = 0; k < 6; k++)
            runB(6'($urandom()), 10'($urandom()), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge clk);
        checkOutput("resultCount", resultsSeen, issued - abandoned);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
